spi_rr_arbiter: RTL and testbench
=================================

// Module: spi_rr_arbiter
// PURPOSE
//  Shares one spi_master byte engine among NUM_REQ requesters using round-robin arbitration.
//  A grant covers a burst of 1..2^LEN_W-1 bytes, and chip select stays owned by one requester
//  for the whole burst. The block sequences spi_start per byte, returns MISO bytes to the winner
//  and aborts a hung byte with a watchdog. Sits between client FSMs and spi_master.
// PARAMETERS
//  NUM_REQ      4     number of requesters (2..8)
//  LEN_W        4     width of per-requester burst length field
//  TIMEOUT_CYC  1024  clk cycles allowed per byte between spi_start and spi_done
//  GAP_CYC      2     idle clk cycles between bursts (cs deassert time)
// PORTS
//  clk          in   1              system clock, rising edge
//  rst          in   1              asynchronous, active-high reset
//  req          in   NUM_REQ        request, level; sampled only in IDLE
//  req_len      in   NUM_REQ*LEN_W  burst length per requester, bytes; 0 is treated as 1
//  tx_data      in   NUM_REQ*8      next byte to send per requester; must be stable from grant/rx_valid to the next spi_start
//  grant        out  NUM_REQ        one-hot owner of the SPI engine; all zero when idle
//  rx_valid     out  NUM_REQ        1-cycle pulse to owner: byte finished, rx_data valid
//  rx_data      out  8              last received MISO byte, held until the next byte completes
//  burst_done   out  NUM_REQ        1-cycle pulse to owner in the cycle its last byte's rx_valid fires
//  timeout_err  out  1              1-cycle pulse on watchdog abort
//  busy         out  1              high in any state other than IDLE
//  spi_start    out  1              to spi_master.start; registered 1-cycle pulse per byte
//  spi_tx       out  8              to spi_master.data_in; registered at spi_start
//  spi_rx       in   8              from spi_master.data_out
//  spi_done     in   1              from spi_master; 1-cycle pulse at end of byte
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr_ptr 0, watchdog and byte counter 0.
//  FSM: IDLE -> LAUNCH -> WAIT -> (LAUNCH | GAP) -> IDLE. All outputs are registered.
//  IDLE:
//   - Any req bit high at edge k: the winner is the first set bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - grant[w] goes high after edge k. Latch cnt = max(req_len[w], 1). Go to LAUNCH.
//  LAUNCH:
//   - spi_start=1 and spi_tx=tx_data[w] for exactly one cycle, which is the cycle after grant rises.
//   - Clear the watchdog. Go to WAIT.
//  WAIT:
//   - spi_done: rx_data<=spi_rx and rx_valid[w] pulses the next cycle; cnt<=cnt-1.
//   - If cnt was 1: burst_done[w] pulses with rx_valid; go to GAP. Else go to LAUNCH.
//   - Byte-to-byte spacing = spi_done -> spi_start in 2 cycles.
//   - Watchdog counts WAIT cycles. At TIMEOUT_CYC with no spi_done: pulse timeout_err, skip
//     rx_valid and burst_done, go to GAP.
//  GAP:
//   - grant held; spi_start stays 0 for GAP_CYC cycles.
//   - Then drop grant, rr_ptr<=(w+1) mod NUM_REQ, go to IDLE.
//   - The earliest re-grant is the cycle after IDLE is entered.
//  Boundary conditions:
//   - req dropped mid-burst is ignored; the burst runs to completion.
//   - req changes outside IDLE are ignored.
//   - spi_done outside WAIT is ignored.
//   - spi_done on the same edge the watchdog expires: spi_done wins and no timeout is flagged.
//   - Single requester held high: repeated bursts, GAP_CYC+1 idle cycles between grants.
//   - All requesters high: strict rotation 0,1,2,3,0 with no starvation.
//   - Reset mid-burst: immediate return to reset values. spi_master shares rst, so no
//     partial byte survives.
// STRUCTURE
//  - spi_pkg.vh: state encodings (IDLE/LAUNCH/WAIT/GAP), SPI_BYTE_W=8, watchdog counter
//    width derived from TIMEOUT_CYC.
//  - Sub-module spi_rr_pick: combinational rotate/priority-encode of req from rr_ptr,
//    outputs the winner index and a valid flag.
//  - FSM, counters and output registers stay in this module.
// TESTING
//  Bench drives a behavioural spi_master that pulses spi_done 16 cycles after spi_start
//  and returns spi_rx = ~spi_tx.
//  1. req=0001, len0=1, tx0=A5 -> grant=0001; one spi_start with spi_tx=A5;
//     rx_valid[0] and burst_done[0] with rx_data=5A; grant drops after GAP_CYC=2 idle cycles.
//  2. req=1111 held, all len=1 -> grant order 0,1,2,3,0; exactly one spi_start per grant.
//  3. len2=3, tx2 advanced on each rx_valid to 11,22,33 -> three spi_start;
//     rx_data 0xEE, 0xDD, 0xCC; burst_done[2] only on the third byte.
//  4. req_len=0 -> exactly one byte transferred.
//  5. Model never asserts spi_done -> timeout_err at TIMEOUT_CYC cycles after spi_start;
//     no rx_valid; grant released; a pending req1 is granted next.
//  6. rst asserted while in WAIT mid-burst -> all outputs 0 immediately; after release,
//     req=0100 is granted first with rr_ptr=0.

Source files
------------

// File: rtl/spi_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin SPI arbiter.
// Defines the state encoding, the byte width and the counter-width helper.
package spi_rr_arbiter_pkg;

   localparam int SPI_BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_GAP    = 2'd3
   } arb_state_e;

   // Bits needed to hold 0..max_val; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/spi_rr_arbiter_pick.sv
// Round-robin winner selection: first set req bit scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
// Purely combinational; valid is low when no request is pending.
module spi_rr_arbiter_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   logic [IDX_W-1:0] winner_s;
   logic             valid_s;
   int               pos_s;

   // Scan from the farthest offset down so the closest requester to rr_ptr wins last.
   always_comb begin
      winner_s = '0;
      valid_s  = 1'b0;
      pos_s    = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         pos_s    = (int'(rr_ptr) + i) % NUM_REQ;
         winner_s = req[pos_s] ? IDX_W'(pos_s) : winner_s;
         valid_s  = req[pos_s] | valid_s;
      end
   end

   assign winner = winner_s;
   assign valid  = valid_s;

endmodule

// File: rtl/spi_rr_arbiter.sv
// Round-robin owner of one spi_master byte engine: grants a requester a whole burst,
// sequences spi_start per byte, returns MISO bytes and aborts hung bytes with a watchdog.
module spi_rr_arbiter
   import spi_rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int LEN_W       = 4,
   parameter int TIMEOUT_CYC = 1024,
   parameter int GAP_CYC     = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ*LEN_W-1:0]    req_len,
   input  logic [NUM_REQ*SPI_BYTE_W-1:0] tx_data,
   output logic [NUM_REQ-1:0]          grant,
   output logic [NUM_REQ-1:0]          rx_valid,
   output logic [SPI_BYTE_W-1:0]       rx_data,
   output logic [NUM_REQ-1:0]          burst_done,
   output logic                        timeout_err,
   output logic                        busy,
   output logic                        spi_start,
   output logic [SPI_BYTE_W-1:0]       spi_tx,
   input  logic [SPI_BYTE_W-1:0]       spi_rx,
   input  logic                        spi_done
);

   localparam int IDX_W  = cnt_width(NUM_REQ - 1);
   localparam int WDOG_W = cnt_width(TIMEOUT_CYC);
   localparam int GAP_W  = cnt_width(GAP_CYC);

   arb_state_e              state_r, state_s;
   logic [IDX_W-1:0]        owner_r, owner_s;
   logic [IDX_W-1:0]        rr_ptr_r, rr_ptr_s;
   logic [NUM_REQ-1:0]      grant_r, grant_s;
   logic [LEN_W-1:0]        cnt_r, cnt_s;
   logic [WDOG_W-1:0]       wdog_r, wdog_s;
   logic [GAP_W-1:0]        gap_r, gap_s;
   logic                    spi_start_r, spi_start_s;
   logic [SPI_BYTE_W-1:0]   spi_tx_r, spi_tx_s;
   logic [SPI_BYTE_W-1:0]   rx_data_r, rx_data_s;
   logic [NUM_REQ-1:0]      rx_valid_r, rx_valid_s;
   logic [NUM_REQ-1:0]      burst_done_r, burst_done_s;
   logic                    timeout_err_r, timeout_err_s;
   logic                    busy_r;
   logic [IDX_W-1:0]        pick_idx_s;
   logic                    pick_valid_s;
   logic [LEN_W-1:0]        len_sel_s;

   spi_rr_arbiter_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req    (req),
      .rr_ptr (rr_ptr_r),
      .winner (pick_idx_s),
      .valid  (pick_valid_s)
   );

   assign len_sel_s = req_len[pick_idx_s*LEN_W +: LEN_W];

   // Next-state and next-output computation for every registered signal.
   always_comb begin
      state_s       = state_r;
      owner_s       = owner_r;
      rr_ptr_s      = rr_ptr_r;
      grant_s       = grant_r;
      cnt_s         = cnt_r;
      wdog_s        = wdog_r;
      gap_s         = gap_r;
      spi_start_s   = 1'b0;
      spi_tx_s      = spi_tx_r;
      rx_data_s     = rx_data_r;
      rx_valid_s    = '0;
      burst_done_s  = '0;
      timeout_err_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pick_valid_s) begin
               state_s = ST_LAUNCH;
               owner_s = pick_idx_s;
               grant_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
               cnt_s   = (len_sel_s == '0) ? LEN_W'(1'b1) : len_sel_s;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LAUNCH: begin
            spi_start_s = 1'b1;
            spi_tx_s    = tx_data[owner_r*SPI_BYTE_W +: SPI_BYTE_W];
            wdog_s      = '0;
            state_s     = ST_WAIT;
         end
         ST_WAIT: begin
            // spi_done is checked first so a completion on the expiry edge is not flagged.
            if (spi_done) begin
               rx_data_s  = spi_rx;
               rx_valid_s = grant_r;
               cnt_s      = cnt_r - LEN_W'(1'b1);
               if (cnt_r == LEN_W'(1'b1)) begin
                  burst_done_s = grant_r;
                  gap_s        = '0;
                  state_s      = ST_GAP;
               end else begin
                  state_s = ST_LAUNCH;
               end
            end else if (wdog_r == WDOG_W'(TIMEOUT_CYC - 1)) begin
               timeout_err_s = 1'b1;
               gap_s         = '0;
               state_s       = ST_GAP;
            end else begin
               wdog_s = wdog_r + WDOG_W'(1'b1);
            end
         end
         ST_GAP: begin
            if (gap_r == GAP_W'(GAP_CYC - 1)) begin
               grant_s  = '0;
               rr_ptr_s = (owner_r == IDX_W'(NUM_REQ - 1)) ? '0 : owner_r + IDX_W'(1'b1);
               state_s  = ST_IDLE;
            end else begin
               gap_s = gap_r + GAP_W'(1'b1);
            end
         end
         default: begin
            grant_s = '0;
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= ST_IDLE;
         owner_r       <= '0;
         rr_ptr_r      <= '0;
         grant_r       <= '0;
         cnt_r         <= '0;
         wdog_r        <= '0;
         gap_r         <= '0;
         spi_start_r   <= 1'b0;
         spi_tx_r      <= '0;
         rx_data_r     <= '0;
         rx_valid_r    <= '0;
         burst_done_r  <= '0;
         timeout_err_r <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_s;
         owner_r       <= owner_s;
         rr_ptr_r      <= rr_ptr_s;
         grant_r       <= grant_s;
         cnt_r         <= cnt_s;
         wdog_r        <= wdog_s;
         gap_r         <= gap_s;
         spi_start_r   <= spi_start_s;
         spi_tx_r      <= spi_tx_s;
         rx_data_r     <= rx_data_s;
         rx_valid_r    <= rx_valid_s;
         burst_done_r  <= burst_done_s;
         timeout_err_r <= timeout_err_s;
         busy_r        <= (state_s != ST_IDLE);
      end
   end

   assign grant       = grant_r;
   assign rx_valid    = rx_valid_r;
   assign rx_data     = rx_data_r;
   assign burst_done  = burst_done_r;
   assign timeout_err = timeout_err_r;
   assign busy        = busy_r;
   assign spi_start   = spi_start_r;
   assign spi_tx      = spi_tx_r;

endmodule

// File: tb/tb_spi_rr_arbiter.sv
// Directed self-checking bench for spi_rr_arbiter with a behavioural spi_master
// that answers ~spi_tx with spi_done 16 cycles after spi_start.
module tb_spi_rr_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [15:0] req_len;
   logic [31:0] tx_data;
   logic [3:0]  grant;
   logic [3:0]  rx_valid;
   logic [7:0]  rx_data;
   logic [3:0]  burst_done;
   logic        timeout_err;
   logic        busy;
   logic        spi_start;
   logic [7:0]  spi_tx;
   logic [7:0]  spi_rx;
   logic        spi_done;

   logic        model_en;
   logic [4:0]  m_cnt;
   logic [7:0]  m_tx;

   int checks;
   int failures;
   int n_start, n_rxv, n_bd, n_to;
   logic [3:0] prev_grant;
   logic [3:0] grant_q[$];
   logic [7:0] rx_q[$];
   logic [3:0] bd_q[$];

   spi_rr_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_len     (req_len),
      .tx_data     (tx_data),
      .grant       (grant),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .burst_done  (burst_done),
      .timeout_err (timeout_err),
      .busy        (busy),
      .spi_start   (spi_start),
      .spi_tx      (spi_tx),
      .spi_rx      (spi_rx),
      .spi_done    (spi_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural spi_master: spi_done rises 16 cycles after spi_start, returning ~spi_tx.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt    <= 5'd0;
         m_tx     <= 8'h00;
         spi_done <= 1'b0;
         spi_rx   <= 8'h00;
      end else begin
         spi_done <= 1'b0;
         if (spi_start && model_en) begin
            m_cnt <= 5'd15;
            m_tx  <= spi_tx;
         end else if (m_cnt != 5'd0) begin
            m_cnt <= m_cnt - 5'd1;
            if (m_cnt == 5'd1) begin
               spi_done <= 1'b1;
               spi_rx   <= ~m_tx;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      n_start = 0; n_rxv = 0; n_bd = 0; n_to = 0;
      prev_grant = grant;
      grant_q.delete(); rx_q.delete(); bd_q.delete();
   endtask

   task automatic tick();
      @(negedge clk);
      if (spi_start) n_start++;
      if (grant != 4'b0000 && grant != prev_grant) grant_q.push_back(grant);
      prev_grant = grant;
      if (rx_valid != 4'b0000) begin
         n_rxv++;
         rx_q.push_back(rx_data);
         bd_q.push_back(burst_done);
      end
      if (burst_done != 4'b0000) n_bd++;
      if (timeout_err) n_to++;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 300) begin
         tick();
         n++;
      end
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int n;
      int k;
      checks = 0; failures = 0;
      model_en = 1'b1;
      req = 4'b0000;
      req_len = 16'h1111;
      tx_data = 32'h44332211;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_grant", {28'd0, grant}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_spi_start", {31'd0, spi_start}, 32'd0);
      check("rst_rx_valid", {28'd0, rx_valid}, 32'd0);
      check("rst_rx_data", {24'd0, rx_data}, 32'd0);
      check("rst_timeout", {31'd0, timeout_err}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // 1: single byte from requester 0
      tx_data[7:0] = 8'hA5;
      clear_mon();
      req = 4'b0001;
      tick();
      check("t1_grant", {28'd0, grant}, 32'h1);
      check("t1_busy", {31'd0, busy}, 32'd1);
      check("t1_no_early_start", {31'd0, spi_start}, 32'd0);
      tick();
      check("t1_start", {31'd0, spi_start}, 32'd1);
      check("t1_spi_tx", {24'd0, spi_tx}, 32'hA5);
      req = 4'b0000;
      n = 0;
      while (rx_valid == 4'b0000 && n < 40) begin
         tick();
         n++;
      end
      check("t1_rx_valid", {28'd0, rx_valid}, 32'h1);
      check("t1_burst_done", {28'd0, burst_done}, 32'h1);
      check("t1_rx_data", {24'd0, rx_data}, 32'h5A);
      tick();
      check("t1_gap_grant", {28'd0, grant}, 32'h1);
      check("t1_gap_rxv", {28'd0, rx_valid}, 32'd0);
      tick();
      check("t1_grant_drop", {28'd0, grant}, 32'd0);
      check("t1_idle", {31'd0, busy}, 32'd0);
      check("t1_nstart", n_start, 32'd1);

      // 2: all requesters held, strict rotation
      do_reset();
      req_len = 16'h1111;
      clear_mon();
      req = 4'b1111;
      n = 0;
      while (grant_q.size() < 5 && n < 300) begin
         tick();
         n++;
      end
      tick();
      check("t2_ngrants", grant_q.size(), 32'd5);
      for (int i = 0; i < 5; i++) begin
         k = i % 4;
         check($sformatf("t2_order%0d", i), {28'd0, grant_q[i]}, 32'd1 << k);
      end
      check("t2_nstart", n_start, 32'd5);
      req = 4'b0000;
      wait_idle("t2_idle");

      // 3: three-byte burst on requester 2 with tx advanced per rx_valid
      do_reset();
      req_len[11:8] = 4'd3;
      tx_data[23:16] = 8'h11;
      clear_mon();
      req = 4'b0100;
      tick();
      check("t3_grant", {28'd0, grant}, 32'h4);
      req = 4'b0000;
      k = 0;
      n = 0;
      while (grant != 4'b0000 && n < 200) begin
         tick();
         if (rx_valid[2]) begin
            k++;
            tx_data[23:16] = (k == 1) ? 8'h22 : 8'h33;
         end
         n++;
      end
      check("t3_nstart", n_start, 32'd3);
      check("t3_nrx", rx_q.size(), 32'd3);
      check("t3_rx0", {24'd0, rx_q[0]}, 32'hEE);
      check("t3_rx1", {24'd0, rx_q[1]}, 32'hDD);
      check("t3_rx2", {24'd0, rx_q[2]}, 32'hCC);
      check("t3_bd0", {28'd0, bd_q[0]}, 32'd0);
      check("t3_bd1", {28'd0, bd_q[1]}, 32'd0);
      check("t3_bd2", {28'd0, bd_q[2]}, 32'h4);
      check("t3_nbd", n_bd, 32'd1);

      // 4: zero length behaves as one byte
      req_len[11:8] = 4'd0;
      tx_data[23:16] = 8'h3C;
      clear_mon();
      req = 4'b0100;
      tick();
      check("t4_grant", {28'd0, grant}, 32'h4);
      req = 4'b0000;
      wait_idle("t4_idle");
      check("t4_nstart", n_start, 32'd1);
      check("t4_nrx", n_rxv, 32'd1);
      check("t4_rx_data", {24'd0, rx_data}, 32'hC3);
      check("t4_nbd", n_bd, 32'd1);

      // 5: watchdog abort, then pending requester 1 is served
      clear_mon();
      model_en = 1'b0;
      req_len[3:0] = 4'd1;
      req = 4'b0001;
      tick();
      check("t5_grant", {28'd0, grant}, 32'h1);
      req = 4'b0011;
      tick();
      check("t5_start", {31'd0, spi_start}, 32'd1);
      n = 0;
      while (!timeout_err && n < 1100) begin
         tick();
         n++;
      end
      check("t5_to_latency", n, 32'd1024);
      check("t5_no_rxv", n_rxv, 32'd0);
      check("t5_no_bd", n_bd, 32'd0);
      model_en = 1'b1;
      n = 0;
      while (grant != 4'b0010 && n < 20) begin
         tick();
         n++;
      end
      check("t5_next_grant", {28'd0, grant}, 32'h2);
      check("t5_nto", n_to, 32'd1);
      req = 4'b0000;
      wait_idle("t5_idle");

      // 6: reset mid-burst
      req_len[7:4] = 4'd3;
      clear_mon();
      req = 4'b0010;
      tick();
      check("t6_grant", {28'd0, grant}, 32'h2);
      req = 4'b0000;
      n = 0;
      while (n_start < 2 && n < 100) begin
         tick();
         n++;
      end
      repeat (3) tick();
      check("t6_pre_busy", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      check("t6_rst_grant", {28'd0, grant}, 32'd0);
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_rx_data", {24'd0, rx_data}, 32'd0);
      check("t6_rst_spi_tx", {24'd0, spi_tx}, 32'd0);
      check("t6_rst_start", {31'd0, spi_start}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      clear_mon();
      req = 4'b0100;
      tick();
      check("t6_regrant", {28'd0, grant}, 32'h4);
      tick();
      check("t6_restart", {31'd0, spi_start}, 32'd1);
      req = 4'b0000;
      wait_idle("t6_idle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
